// File: rtl/core_if_pc_gen.sv
// Fetch-stage PC generator: one outstanding imem request, static next-PC prediction, IF/ID slot.
// Optional return-address stack enabled by defining CORE_IF_RAS_EN.
module core_if_pc_gen #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_ireq_valid,
   output logic [31:0] o_ireq_addr,
   input  logic        i_ireq_ready,
   input  logic        i_irsp_valid,
   input  logic [31:0] i_irsp_inst,
   output logic [31:0] o_pd_inst,
   input  logic        i_pd_flag_jal,
   input  logic        i_pd_flag_jalr,
   input  logic        i_pd_flag_branch,
   input  logic [31:0] i_pd_bj_imm,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_inst,
   output logic        o_if_pred_taken,
   output logic [31:0] o_if_pred_pc,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_inst;
   logic        r_if_pred_taken;
   logic [31:0] r_if_pred_pc;

   logic        w_free;
   logic        w_ireq_valid;
   logic        w_accept;
   logic        w_load;
   logic [31:0] w_pc4;
   logic [31:0] w_tgt;
   logic        w_pred_taken;
   logic [31:0] w_pred_pc;
   logic        w_ras_hit;
   logic [31:0] w_ras_top_val;

   assign w_free       = !r_if_valid || i_if_ready;
   assign w_ireq_valid = !rst && (r_state == S_REQ) && w_free;
   assign w_accept     = w_ireq_valid && i_ireq_ready;
   assign w_load       = (r_state == S_WAIT) && i_irsp_valid && !i_flush;
   assign w_pc4        = r_pc + 32'd4;
   assign w_tgt        = r_pc + i_pd_bj_imm;

   assign o_ireq_valid    = w_ireq_valid;
   assign o_ireq_addr     = w_ireq_valid ? {r_pc[31:2], 2'b00} : '0;
   assign o_pd_inst       = i_irsp_inst;
   assign o_if_valid      = r_if_valid;
   assign o_if_pc         = r_if_pc;
   assign o_if_inst       = r_if_inst;
   assign o_if_pred_taken = r_if_pred_taken;
   assign o_if_pred_pc    = r_if_pred_pc;

   always_comb begin
      w_pred_taken = 1'b0;
      w_pred_pc    = w_pc4;
      if (i_pd_flag_jal) begin
         w_pred_taken = 1'b1;
         w_pred_pc    = w_tgt;
      end else if (i_pd_flag_jalr) begin
         if (w_ras_hit) begin
            w_pred_taken = 1'b1;
            w_pred_pc    = w_ras_top_val;
         end
      end else if (i_pd_flag_branch && i_pd_bj_imm[31]) begin
         w_pred_taken = 1'b1;
         w_pred_pc    = w_tgt;
      end
   end

`ifdef CORE_IF_RAS_EN
   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PW-1:0] TOP_MAX = PW'(RAS_DEPTH - 1);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(RAS_DEPTH);

   logic [31:0]   r_ras [RAS_DEPTH];
   logic [PW-1:0] r_ras_top;
   logic [PW:0]   r_ras_cnt;
   logic          w_rd_link;
   logic          w_rs1_link;
   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_top_inc;
   logic [PW-1:0] w_top_dec;

   assign w_rd_link     = (i_irsp_inst[11:7] == 5'd1) || (i_irsp_inst[11:7] == 5'd5);
   assign w_rs1_link    = (i_irsp_inst[19:15] == 5'd1) || (i_irsp_inst[19:15] == 5'd5);
   assign w_push        = (i_pd_flag_jal || i_pd_flag_jalr) && w_rd_link;
   assign w_pop         = i_pd_flag_jalr && (i_irsp_inst[11:7] == 5'd0) && w_rs1_link &&
                          (i_pd_bj_imm == 32'd0);
   assign w_ras_hit     = w_pop && (r_ras_cnt != '0);
   assign w_ras_top_val = r_ras[r_ras_top];
   assign w_top_inc     = (r_ras_top == TOP_MAX) ? '0 : r_ras_top + 1'b1;
   assign w_top_dec     = (r_ras_top == '0) ? TOP_MAX : r_ras_top - 1'b1;

   // Pop-then-push collapses to overwriting the current top in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ras_top <= '0;
         r_ras_cnt <= '0;
      end else if (w_load) begin
         if (w_ras_hit && w_push) begin
            r_ras[r_ras_top] <= w_pc4;
         end else if (w_ras_hit) begin
            r_ras_top <= w_top_dec;
            r_ras_cnt <= r_ras_cnt - 1'b1;
         end else if (w_push) begin
            r_ras[w_top_inc] <= w_pc4;
            r_ras_top        <= w_top_inc;
            if (r_ras_cnt != CNT_MAX) r_ras_cnt <= r_ras_cnt + 1'b1;
         end
      end
   end
`else
   logic w_unused;
   assign w_ras_hit     = 1'b0;
   assign w_ras_top_val = '0;
   assign w_unused      = (RAS_DEPTH == 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_REQ;
         r_pc            <= RESET_PC;
         r_if_valid      <= 1'b0;
         r_if_pc         <= '0;
         r_if_inst       <= '0;
         r_if_pred_taken <= 1'b0;
         r_if_pred_pc    <= '0;
      end else if (i_flush) begin
         r_pc       <= i_flush_pc;
         r_if_valid <= 1'b0;
         if ((r_state == S_WAIT) || (r_state == S_DROP) || w_accept) r_state <= S_DROP;
         else r_state <= S_REQ;
      end else begin
         if (r_if_valid && i_if_ready) r_if_valid <= 1'b0;
         case (r_state)
            S_REQ: begin
               if (w_accept) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_irsp_valid) begin
                  r_if_valid      <= 1'b1;
                  r_if_pc         <= r_pc;
                  r_if_inst       <= i_irsp_inst;
                  r_if_pred_taken <= w_pred_taken;
                  r_if_pred_pc    <= w_pred_pc;
                  r_pc            <= w_pred_pc;
                  r_state         <= S_REQ;
               end
            end
            S_DROP: begin
               if (i_irsp_valid) r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_if_pc_gen.sv
// Directed bench for core_if_pc_gen: a small imem responder with per-address pre-decode entries.
module tb_core_if_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_ireq_valid;
   logic [31:0] o_ireq_addr;
   logic        i_ireq_ready;
   logic        i_irsp_valid;
   logic [31:0] i_irsp_inst;
   logic [31:0] o_pd_inst;
   logic        i_pd_flag_jal;
   logic        i_pd_flag_jalr;
   logic        i_pd_flag_branch;
   logic [31:0] i_pd_bj_imm;
   logic        o_if_valid;
   logic        i_if_ready;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_inst;
   logic        o_if_pred_taken;
   logic [31:0] o_if_pred_pc;
   logic        i_flush;
   logic [31:0] i_flush_pc;

   always #5 clk = ~clk;

   core_if_pc_gen #(.RESET_PC(32'h8000_0000), .RAS_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst),
      .o_ireq_valid(o_ireq_valid), .o_ireq_addr(o_ireq_addr), .i_ireq_ready(i_ireq_ready),
      .i_irsp_valid(i_irsp_valid), .i_irsp_inst(i_irsp_inst), .o_pd_inst(o_pd_inst),
      .i_pd_flag_jal(i_pd_flag_jal), .i_pd_flag_jalr(i_pd_flag_jalr),
      .i_pd_flag_branch(i_pd_flag_branch), .i_pd_bj_imm(i_pd_bj_imm),
      .o_if_valid(o_if_valid), .i_if_ready(i_if_ready), .o_if_pc(o_if_pc),
      .o_if_inst(o_if_inst), .o_if_pred_taken(o_if_pred_taken), .o_if_pred_pc(o_if_pred_pc),
      .i_flush(i_flush), .i_flush_pc(i_flush_pc)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      logic        jal;
      logic        jalr;
      logic        br;
      logic [31:0] imm;
   } ment_t;

   localparam logic [31:0] ADDI = 32'h0000_0013;

   ment_t       mem [4];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned lat   = 0;
   logic        pend  = 1'b0;
   int unsigned pcnt  = 0;
   logic [31:0] paddr = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic set_mem(input int idx, input logic [31:0] a, input logic [31:0] inst,
                          input logic j, input logic jr, input logic b, input logic [31:0] imm);
      mem[idx].addr = a;
      mem[idx].inst = inst;
      mem[idx].jal  = j;
      mem[idx].jalr = jr;
      mem[idx].br   = b;
      mem[idx].imm  = imm;
   endtask

   task automatic present(input logic [31:0] a);
      i_irsp_valid     = 1'b1;
      i_irsp_inst      = ADDI;
      i_pd_flag_jal    = 1'b0;
      i_pd_flag_jalr   = 1'b0;
      i_pd_flag_branch = 1'b0;
      i_pd_bj_imm      = '0;
      for (int i = 0; i < 4; i++) begin
         if (mem[i].addr == a) begin
            i_irsp_inst      = mem[i].inst;
            i_pd_flag_jal    = mem[i].jal;
            i_pd_flag_jalr   = mem[i].jalr;
            i_pd_flag_branch = mem[i].br;
            i_pd_bj_imm      = mem[i].imm;
         end
      end
   endtask

   // Request handshake is sampled at a quiet point before the edge; response follows after lat cycles.
   task automatic tick();
      logic        fire;
      logic [31:0] faddr;
      fire  = o_ireq_valid && i_ireq_ready;
      faddr = o_ireq_addr;
      @(posedge clk);
      #1;
      i_irsp_valid     = 1'b0;
      i_irsp_inst      = '0;
      i_pd_flag_jal    = 1'b0;
      i_pd_flag_jalr   = 1'b0;
      i_pd_flag_branch = 1'b0;
      i_pd_bj_imm      = '0;
      if (fire) begin
         pend  = 1'b1;
         pcnt  = lat;
         paddr = faddr;
      end
      if (pend) begin
         if (pcnt == 0) begin
            present(paddr);
            pend = 1'b0;
         end else begin
            pcnt--;
         end
      end
      #1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      i_ireq_ready = 1'b0;
      i_flush      = 1'b1;
      i_flush_pc   = pc;
      #1;
      tick();
      i_flush      = 1'b0;
      i_ireq_ready = 1'b1;
      #1;
   endtask

   task automatic fetch(input string tag, input logic [31:0] exp_addr);
      int unsigned k;
      k = 0;
      while (!o_ireq_valid && k < 20) begin tick(); k++; end
      check({tag, "_req"}, {31'd0, o_ireq_valid}, 32'd1);
      check({tag, "_addr"}, o_ireq_addr, exp_addr);
      tick();
      k = 0;
      while (!o_if_valid && k < 40) begin tick(); k++; end
      check({tag, "_load"}, {31'd0, o_if_valid}, 32'd1);
      check({tag, "_pc"}, o_if_pc, exp_addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) set_mem(i, 32'hFFFF_FFFF, ADDI, 1'b0, 1'b0, 1'b0, '0);
      rst = 1'b1; i_ireq_ready = 1'b1; i_if_ready = 1'b1; i_flush = 1'b0; i_flush_pc = '0;
      i_irsp_valid = 1'b0; i_irsp_inst = '0; i_pd_flag_jal = 1'b0; i_pd_flag_jalr = 1'b0;
      i_pd_flag_branch = 1'b0; i_pd_bj_imm = '0;
      tick(); tick();
      check("rst_ireq_valid", {31'd0, o_ireq_valid}, 32'd0);
      check("rst_ireq_addr", o_ireq_addr, 32'd0);
      check("rst_if_valid", {31'd0, o_if_valid}, 32'd0);
      check("rst_if_pc", o_if_pc, 32'd0);
      check("rst_pred", {o_if_pred_pc[30:0], o_if_pred_taken}, 32'd0);

      // 1: sequential fetch after reset
      rst = 1'b0; #1;
      check("t1_req0", {31'd0, o_ireq_valid}, 32'd1);
      check("t1_addr0", o_ireq_addr, 32'h8000_0000);
      tick();
      check("t1_wait_noreq", {31'd0, o_ireq_valid}, 32'd0);
      check("t1_pd_inst", o_pd_inst, ADDI);
      tick();
      check("t1_slot_valid", {31'd0, o_if_valid}, 32'd1);
      check("t1_slot_pc", o_if_pc, 32'h8000_0000);
      check("t1_slot_inst", o_if_inst, ADDI);
      check("t1_pred_taken", {31'd0, o_if_pred_taken}, 32'd0);
      check("t1_pred_pc", o_if_pred_pc, 32'h8000_0004);
      check("t1_addr1", o_ireq_addr, 32'h8000_0004);

      // 2: jal +0x100, rd=x0
      set_mem(0, 32'h8000_0010, 32'h1000_006F, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
      redirect(32'h8000_0010);
      check("t2_flush_clr", {31'd0, o_if_valid}, 32'd0);
      fetch("t2", 32'h8000_0010);
      check("t2_pred_taken", {31'd0, o_if_pred_taken}, 32'd1);
      check("t2_pred_pc", o_if_pred_pc, 32'h8000_0110);
      check("t2_next_addr", o_ireq_addr, 32'h8000_0110);

      // 3: backward branch taken, forward branch not taken
      set_mem(1, 32'h8000_0020, 32'hFE00_0CE3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      redirect(32'h8000_0020);
      fetch("t3b", 32'h8000_0020);
      check("t3b_pred_taken", {31'd0, o_if_pred_taken}, 32'd1);
      check("t3b_pred_pc", o_if_pred_pc, 32'h8000_0018);
      check("t3b_next_addr", o_ireq_addr, 32'h8000_0018);
      set_mem(1, 32'h8000_0020, 32'h0000_0463, 1'b0, 1'b0, 1'b1, 32'h0000_0008);
      redirect(32'h8000_0020);
      fetch("t3f", 32'h8000_0020);
      check("t3f_pred_taken", {31'd0, o_if_pred_taken}, 32'd0);
      check("t3f_pred_pc", o_if_pred_pc, 32'h8000_0024);

      // 4: ID stall holds the slot and gates issue
      i_if_ready = 1'b0; #1;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_noreq", {31'd0, o_ireq_valid}, 32'd0);
         check("t4_hold_pc", o_if_pc, 32'h8000_0020);
         check("t4_hold_valid", {31'd0, o_if_valid}, 32'd1);
         tick();
      end
      lat = 3;
      i_if_ready = 1'b1; #1;
      check("t4_release_req", {31'd0, o_ireq_valid}, 32'd1);
      check("t4_release_addr", o_ireq_addr, 32'h8000_0024);
      tick();
      check("t4_slot_cleared", {31'd0, o_if_valid}, 32'd0);

      // 5: flush while waiting; stale response must not load
      i_flush = 1'b1; i_flush_pc = 32'h8000_4000; #1;
      tick();
      i_flush = 1'b0; #1;
      check("t5_drop_noreq", {31'd0, o_ireq_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (!o_ireq_valid) begin
            check("t5_drop_noslot", {31'd0, o_if_valid}, 32'd0);
            tick();
         end
      end
      lat = 0;
      check("t5_after_noslot", {31'd0, o_if_valid}, 32'd0);
      fetch("t5", 32'h8000_4000);
      check("t5_inst", o_if_inst, ADDI);

      // 6: return-address stack
      set_mem(0, 32'h8000_0200, 32'h0000_8067, 1'b0, 1'b1, 1'b0, 32'd0);
      set_mem(1, 32'h8000_0000, 32'h1000_00EF, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
      set_mem(2, 32'h8000_0100, 32'h0000_8067, 1'b0, 1'b1, 1'b0, 32'd0);
      redirect(32'h8000_0200);
      fetch("t6_empty", 32'h8000_0200);
      check("t6_empty_taken", {31'd0, o_if_pred_taken}, 32'd0);
      check("t6_empty_pc", o_if_pred_pc, 32'h8000_0204);
      redirect(32'h8000_0000);
      fetch("t6_jal", 32'h8000_0000);
      check("t6_jal_taken", {31'd0, o_if_pred_taken}, 32'd1);
      check("t6_jal_pc", o_if_pred_pc, 32'h8000_0100);
      fetch("t6_ret", 32'h8000_0100);
`ifdef CORE_IF_RAS_EN
      check("t6_ret_taken", {31'd0, o_if_pred_taken}, 32'd1);
      check("t6_ret_pc", o_if_pred_pc, 32'h8000_0004);
      check("t6_ret_next", o_ireq_addr, 32'h8000_0004);
`else
      check("t6_ret_taken", {31'd0, o_if_pred_taken}, 32'd0);
      check("t6_ret_pc", o_if_pred_pc, 32'h8000_0104);
      check("t6_ret_next", o_ireq_addr, 32'h8000_0104);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
